// File: rtl/apb_master_arb_if.sv
// Bundle shared by the round-robin APB master and its agents: requester
// handshake, response pulses and the APB bus (PSel/PEnable/PWrite/PAddr/PWData/PRData).
interface apb_master_arb_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    PSel;
    logic                    PEnable;
    logic                    PWrite;
    logic [ADDR_W-1:0]       PAddr;
    logic [DATA_W-1:0]       PWData;
    logic [DATA_W-1:0]       PRData;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRData,
        output req_ready, rsp_valid, rsp_rdata,
        output PSel, PEnable, PWrite, PAddr, PWData
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRData,
        input  req_ready, rsp_valid, rsp_rdata,
        input  PSel, PEnable, PWrite, PAddr, PWData
    );
endinterface

// File: rtl/apb_master_arb.sv
// Round-robin APB master sharing one APB bus between N_REQ requesters.
// Optional macro ARB_PRIO0_EN: requester 0 gets absolute priority over the round robin.
module apb_master_arb #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic             PClk,
    input  logic             Rst,
    apb_master_arb_if.master bus
);
    localparam int               IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W:0]   N_REQ_W  = (IDX_W + 1)'(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state;
    logic [IDX_W-1:0]  rr;
    logic [IDX_W-1:0]  gnt;

    logic [ADDR_W-1:0] addr_arr  [N_REQ];
    logic [DATA_W-1:0] wdata_arr [N_REQ];

    logic              rr_valid;
    logic [IDX_W-1:0]  rr_win;
    logic              win_valid;
    logic [IDX_W-1:0]  win;
    logic              adv_rr;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // First asserted req_valid at or after the rr pointer, wrapping modulo N_REQ.
    always_comb begin : rr_search
        logic [IDX_W:0] sum;
        sum      = '0;
        rr_valid = 1'b0;
        rr_win   = '0;
        for (int off = 0; off < N_REQ; off++) begin
            sum = {1'b0, rr} + (IDX_W + 1)'(off);
            if (sum >= N_REQ_W) begin
                sum = sum - N_REQ_W;
            end
            if (!rr_valid && bus.req_valid[sum[IDX_W-1:0]]) begin
                rr_valid = 1'b1;
                rr_win   = sum[IDX_W-1:0];
            end
        end
    end

`ifdef ARB_PRIO0_EN
    // Requester 0 pre-empts the rotation and never moves the pointer.
    always_comb begin
        win_valid = rr_valid;
        win       = rr_win;
        adv_rr    = 1'b1;
        if (bus.req_valid[0]) begin
            win_valid = 1'b1;
            win       = '0;
            adv_rr    = 1'b0;
        end
    end
`else
    assign win_valid = rr_valid;
    assign win       = rr_win;
    assign adv_rr    = 1'b1;
`endif

    always_ff @(posedge PClk or negedge Rst) begin
        if (!Rst) begin
            state         <= IDLE;
            rr            <= '0;
            gnt           <= '0;
            bus.PSel      <= 1'b0;
            bus.PEnable   <= 1'b0;
            bus.PWrite    <= 1'b0;
            bus.PAddr     <= '0;
            bus.PWData    <= '0;
            bus.req_ready <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.req_ready <= '0;
            bus.rsp_valid <= '0;
            case (state)
                IDLE: begin
                end
                SETUP: begin
                    bus.PEnable <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    bus.rsp_valid[gnt] <= 1'b1;
                    if (!bus.PWrite) begin
                        bus.rsp_rdata <= bus.PRData;
                    end
                    bus.PSel    <= 1'b0;
                    bus.PEnable <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A grant from IDLE or ACCESS overrides the return-to-idle above,
            // which gives back-to-back transfers with PSel held high.
            if (state != SETUP && win_valid) begin
                bus.PSel            <= 1'b1;
                bus.PEnable         <= 1'b0;
                bus.PWrite          <= bus.req_write[win];
                bus.PAddr           <= addr_arr[win];
                bus.PWData          <= wdata_arr[win];
                bus.req_ready[win]  <= 1'b1;
                gnt                 <= win;
                state               <= SETUP;
                if (adv_rr) begin
                    rr <= (win == LAST_IDX) ? '0 : win + IDX_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_apb_master_arb.sv
// Scoreboard bench for apb_master_arb (N_REQ=4): directed requests with hand-computed
// grant order and read data, checked by a monitor decoupled from the stimulus.
`timescale 1ns/1ps
module tb_apb_master_arb;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [1:0]    id;
        logic          wr;
        logic [AW-1:0] addr;
        logic [7:0]    gap;
        logic [DW-1:0] data;
    } txn_t;

    logic PClk = 1'b0;
    logic Rst  = 1'b1;
    int   cyc  = 0;
    int   checks = 0;
    int   errors = 0;

    cmd_t cmdq [N][$];
    txn_t exp_gnt[$];
    txn_t exp_rsp[$];

    logic [DW-1:0] mem [256];

    always #5 PClk = ~PClk;
    always @(posedge PClk) cyc <= cyc + 1;

    apb_master_arb_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();

    apb_master_arb #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .PClk (PClk),
        .Rst  (Rst),
        .bus  (bus)
    );

    // APB slave: word memory with memory[i] = i after reset.
    assign bus.PRData = mem[bus.PAddr[7:0]];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = DW'(i);
        forever begin
            @(posedge PClk);
            if (bus.PSel && bus.PEnable && bus.PWrite) mem[bus.PAddr[7:0]] <= bus.PWData;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic req(input int id, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        cmd_t c;
        c.wr = wr; c.addr = addr; c.wdata = wd;
        cmdq[id].push_back(c);
    endtask

    task automatic expect_txn(input int id, input logic wr, input logic [AW-1:0] addr,
                              input int gap, input logic [DW-1:0] data);
        txn_t t;
        t.id = 2'(id); t.wr = wr; t.addr = addr; t.gap = 8'(gap); t.data = data;
        exp_gnt.push_back(t);
        exp_rsp.push_back(t);
    endtask

    function automatic int pending();
        int n = exp_rsp.size() + exp_gnt.size();
        for (int i = 0; i < N; i++) n += cmdq[i].size();
        return n;
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        while (pending() != 0 && n < 300) begin
            @(posedge PClk);
            n++;
        end
        chk({"drain_", tag}, 64'(pending()), 64'd0);
        repeat (3) @(posedge PClk);
        #2;
    endtask

    // Requester agents: hold the head command until its req_ready is seen.
    initial begin
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        forever begin
            @(negedge PClk);
            for (int i = 0; i < N; i++) begin
                if (bus.req_ready[i] && cmdq[i].size() > 0) void'(cmdq[i].pop_front());
                if (cmdq[i].size() > 0) begin
                    bus.req_valid[i]              = 1'b1;
                    bus.req_write[i]              = cmdq[i][0].wr;
                    bus.req_addr[i*AW +: AW]      = cmdq[i][0].addr;
                    bus.req_wdata[i*DW +: DW]     = cmdq[i][0].wdata;
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: grants, responses and APB phase ordering.
    initial begin
        int gcyc [N];
        int last_gcyc;
        logic prev_sel, prev_en, prev_wr;
        logic [AW-1:0] prev_addr;
        logic [N-1:0] oh;
        txn_t t;
        last_gcyc = 0;
        prev_sel = 1'b0; prev_en = 1'b0; prev_wr = 1'b0; prev_addr = '0;
        for (int i = 0; i < N; i++) gcyc[i] = 0;
        forever begin
            @(negedge PClk);
            if (Rst) begin
                if (bus.rsp_valid != '0) begin
                    if (exp_rsp.size() == 0) begin
                        chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
                    end else begin
                        t = exp_rsp.pop_front();
                        oh = '0; oh[t.id] = 1'b1;
                        chk("rsp_id", 64'(bus.rsp_valid), 64'(oh));
                        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(t.data));
                        chk("rsp_latency", 64'(cyc - gcyc[t.id]), 64'd2);
                        $display("txn req%0d %s addr=%h rdata=%h t=%0t", t.id, t.wr ? "WR" : "RD",
                                 t.addr, bus.rsp_rdata, $time);
                    end
                end
                if (bus.req_ready != '0) begin
                    if (exp_gnt.size() == 0) begin
                        chk("gnt_unexpected", 64'(bus.req_ready), 64'd0);
                    end else begin
                        t = exp_gnt.pop_front();
                        oh = '0; oh[t.id] = 1'b1;
                        chk("gnt_id", 64'(bus.req_ready), 64'(oh));
                        chk("gnt_paddr", 64'(bus.PAddr), 64'(t.addr));
                        chk("gnt_pwrite", 64'(bus.PWrite), 64'(t.wr));
                        chk("gnt_setup_phase", 64'({bus.PSel, bus.PEnable}), 64'b10);
                        if (t.gap != 0) chk("gnt_gap", 64'(cyc - last_gcyc), 64'(t.gap));
                        last_gcyc = cyc;
                        gcyc[t.id] = cyc;
                    end
                end
                if (bus.PEnable) begin
                    chk("access_psel", 64'(bus.PSel), 64'd1);
                    chk("access_after_setup", 64'({prev_sel, prev_en}), 64'b10);
                    chk("access_paddr_held", 64'(bus.PAddr), 64'(prev_addr));
                    chk("access_pwrite_held", 64'(bus.PWrite), 64'(prev_wr));
                end
                prev_sel = bus.PSel; prev_en = bus.PEnable;
                prev_wr = bus.PWrite; prev_addr = bus.PAddr;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Stimulus with hand-computed expectations.
    initial begin
        int order [4];
        int id;
        logic found;

        #1 Rst = 1'b0;
        repeat (3) @(posedge PClk);
        #2;
        chk("rst_psel", 64'(bus.PSel), 64'd0);
        chk("rst_penable", 64'(bus.PEnable), 64'd0);
        chk("rst_pwrite", 64'(bus.PWrite), 64'd0);
        chk("rst_paddr", 64'(bus.PAddr), 64'd0);
        chk("rst_pwdata", 64'(bus.PWData), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        @(negedge PClk);
        Rst = 1'b1;
        @(posedge PClk);
        #2;

        // Single read of the reset memory.
        req(0, 1'b0, 32'h10, 32'h0);
        expect_txn(0, 1'b0, 32'h10, 0, 32'h10);
        wait_idle("single_read");

        // Write then read from requester 1; the write leaves rsp_rdata at 0x10.
        req(1, 1'b1, 32'h20, 32'hDEADBEEF);
        req(1, 1'b0, 32'h20, 32'h0);
        expect_txn(1, 1'b1, 32'h20, 0, 32'h10);
        expect_txn(1, 1'b0, 32'h20, 2, 32'hDEADBEEF);
        wait_idle("write_read");

        // Contention between requesters 0 and 1 (rr starts at 2).
        for (int k = 0; k < 3; k++) begin
            req(0, 1'b0, 32'h1, 32'h0);
            req(1, 1'b0, 32'h2, 32'h0);
        end
        for (int k = 0; k < 6; k++) begin
`ifdef ARB_PRIO0_EN
            id = (k < 3) ? 0 : 1;
`else
            id = k % 2;
`endif
            expect_txn(id, 1'b0, (id == 1) ? 32'h2 : 32'h1, (k == 0) ? 0 : 2, (id == 1) ? 32'h2 : 32'h1);
        end
        wait_idle("contention");

        // Move rr to 3, then all four request together.
        req(2, 1'b0, 32'h30, 32'h0);
        expect_txn(2, 1'b0, 32'h30, 0, 32'h30);
        wait_idle("set_rr3");
`ifdef ARB_PRIO0_EN
        order = '{0, 3, 1, 2};
`else
        order = '{3, 0, 1, 2};
`endif
        for (int i = 0; i < N; i++) req(i, 1'b0, 32'h40 + 32'(i), 32'h0);
        for (int k = 0; k < 4; k++)
            expect_txn(order[k], 1'b0, 32'h40 + 32'(order[k]), (k == 0) ? 0 : 2, 32'h40 + 32'(order[k]));
        wait_idle("wrap");

        // Reset during ACCESS of a requester-1 read; its response must never appear.
        req(1, 1'b0, 32'h5, 32'h0);
        expect_txn(1, 1'b0, 32'h5, 0, 32'h5);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge PClk);
            if (bus.PSel && bus.PEnable) found = 1'b1;
        end
        chk("midrst_reach_access", 64'(found), 64'd1);
        #1 Rst = 1'b0;
        #1;
        chk("midrst_psel", 64'(bus.PSel), 64'd0);
        chk("midrst_penable", 64'(bus.PEnable), 64'd0);
        chk("midrst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("midrst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        exp_rsp.delete();
        repeat (2) @(posedge PClk);
        #2;
        chk("midrst_rsp_held_low", 64'(bus.rsp_valid), 64'd0);
        @(negedge PClk);
        Rst = 1'b1;
        @(posedge PClk);
        #2;
        // rr must be back at 0: requester 0 wins over 2.
        req(0, 1'b0, 32'h6, 32'h0);
        req(2, 1'b0, 32'h7, 32'h0);
        expect_txn(0, 1'b0, 32'h6, 0, 32'h6);
        expect_txn(2, 1'b0, 32'h7, 2, 32'h7);
        wait_idle("after_reset");

        // Requesters 0 and 2 continuously requesting (rr = 3).
        for (int k = 0; k < 3; k++) req(0, 1'b0, 32'h8, 32'h0);
        for (int k = 0; k < 2; k++) req(2, 1'b0, 32'h9, 32'h0);
        for (int k = 0; k < 5; k++) begin
`ifdef ARB_PRIO0_EN
            id = (k < 3) ? 0 : 2;
`else
            id = (k % 2 == 0) ? 0 : 2;
`endif
            expect_txn(id, 1'b0, (id == 2) ? 32'h9 : 32'h8, (k == 0) ? 0 : 2, (id == 2) ? 32'h9 : 32'h8);
        end
        wait_idle("prio0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
